// File: rtl/sdram_pattern_tester_if.sv
// Burst request/response bus between the pattern tester and the SDRAM controller.
interface sdram_pattern_tester_if #(
  parameter int unsigned AW     = 25,
  parameter int unsigned DWIDTH = 16
);
  logic [AW-1:0]     wr_addr;
  logic [DWIDTH-1:0] wr_data;
  logic [3:0]        wr_len;
  logic              wr_req;
  logic              wr_ack;
  logic [AW-1:0]     rd_addr;
  logic [3:0]        rd_len;
  logic              rd_req;
  logic              rd_ack;
  logic              rd_rdy;
  logic [DWIDTH-1:0] rd_data;

  modport master (
    output wr_addr, wr_data, wr_len, wr_req, rd_addr, rd_len, rd_req,
    input  wr_ack, rd_ack, rd_rdy, rd_data
  );

  modport slave (
    input  wr_addr, wr_data, wr_len, wr_req, rd_addr, rd_len, rd_req,
    output wr_ack, rd_ack, rd_rdy, rd_data
  );
endinterface

// File: rtl/sdram_pattern_tester.sv
// Memory pattern generator/checker: writes a pattern over a region in bursts,
// reads it back, counts mismatches and captures the first failing word.
module sdram_pattern_tester #(
  parameter int unsigned     BANKBITS  = 2,
  parameter int unsigned     ROWBITS   = 13,
  parameter int unsigned     COLBITS   = 10,
  parameter int unsigned     DWIDTH    = 16,
  parameter int unsigned     BURST     = 4,
  parameter longint unsigned LAST_ADDR = (64'd1 << (BANKBITS + ROWBITS + COLBITS)) - 64'd1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [1:0]                           mode,
  input  logic                                 loop,
  input  logic [DWIDTH-1:0]                    seed,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error,
  output logic [15:0]                          err_count,
  output logic [BANKBITS+ROWBITS+COLBITS-1:0]  err_addr,
  output logic [DWIDTH-1:0]                    err_exp,
  output logic [DWIDTH-1:0]                    err_got,
  output logic [15:0]                          pass_count,
  sdram_pattern_tester_if.master               bus
);

  localparam int unsigned AW         = BANKBITS + ROWBITS + COLBITS;
  localparam int unsigned CW         = 5;
  localparam logic [AW-1:0] LAST_BURST = AW'(LAST_ADDR + 64'd1 - 64'(BURST));
  localparam logic [AW-1:0] BSTEP    = AW'(BURST);
  localparam logic [CW-1:0] BLAST    = CW'(BURST - 1);
  localparam logic [15:0]   TAPS     = 16'hB400;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WGAP, S_RD, S_RGAP, S_FIN, S_DONE} state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  function automatic logic [15:0] lfsr_seed(input logic [DWIDTH-1:0] sd);
    logic [15:0] s;
    s = 16'(sd);
    return (s == 16'd0) ? 16'd1 : s;
  endfunction

  function automatic logic [DWIDTH-1:0] pattern(input logic [1:0] m, input logic [AW-1:0] a,
                                                input logic [15:0] lf);
    logic [DWIDTH-1:0] f;
    f = DWIDTH'(a) ^ DWIDTH'(a >> DWIDTH);
    case (m)
      2'd0:    pattern = f;
      2'd1:    pattern = ~f;
      2'd2:    pattern = DWIDTH'(lf);
      default: pattern = DWIDTH'(1) << (a % AW'(DWIDTH));
    endcase
  endfunction

  state_t            state;
  logic [1:0]        mode_q;
  logic [DWIDTH-1:0] seed_q;
  logic [15:0]       wr_lf;
  logic [15:0]       rd_lf;
  logic [AW-1:0]     wa;
  logic [AW-1:0]     chk_addr;
  logic [CW-1:0]     wcnt;
  logic [CW-1:0]     rcnt;
  logic              rd_out;
  logic              s1_v;
  logic              s1_stray;
  logic [DWIDTH-1:0] s1_data;
  logic [DWIDTH-1:0] s1_exp;
  logic [AW-1:0]     s1_addr;

  logic              burst_act;
  logic              take;
  logic              mism;
  logic              restart;
  logic [DWIDTH-1:0] exp_c;
  logic [DWIDTH-1:0] wr_next;
  logic [DWIDTH-1:0] first_word;

  assign bus.wr_len = 4'(BURST - 1);
  assign bus.rd_len = 4'(BURST - 1);

  // A word belongs to a burst from the cycle its request is acknowledged.
  assign burst_act  = rd_out | (bus.rd_req & bus.rd_ack);
  assign take       = bus.rd_rdy & burst_act;
  assign mism       = s1_v & (s1_stray | (s1_data != s1_exp));
  assign restart    = (((state == S_IDLE) || (state == S_DONE)) && start) ||
                      ((state == S_FIN) && loop);
  assign exp_c      = pattern(mode_q, chk_addr, rd_lf);
  assign wr_next    = pattern(mode_q, wa + AW'(1), lfsr_step(wr_lf));
  assign first_word = pattern(mode, '0, lfsr_seed(seed));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      mode_q      <= '0;
      seed_q      <= '0;
      wr_lf       <= '0;
      rd_lf       <= '0;
      wa          <= '0;
      chk_addr    <= '0;
      wcnt        <= '0;
      rcnt        <= '0;
      rd_out      <= 1'b0;
      s1_v        <= 1'b0;
      s1_stray    <= 1'b0;
      s1_data     <= '0;
      s1_exp      <= '0;
      s1_addr     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_count   <= '0;
      err_addr    <= '0;
      err_exp     <= '0;
      err_got     <= '0;
      pass_count  <= '0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.wr_req  <= 1'b0;
      bus.rd_addr <= '0;
      bus.rd_req  <= 1'b0;
    end else begin
      // Capture stage: register the returned word with its expected value.
      s1_v <= bus.rd_rdy;
      if (bus.rd_rdy) begin
        s1_stray <= ~burst_act;
        s1_data  <= bus.rd_data;
        s1_exp   <= exp_c;
        s1_addr  <= chk_addr;
      end
      if (take) begin
        chk_addr <= chk_addr + AW'(1);
        rd_lf    <= lfsr_step(rd_lf);
      end

      // Compare stage.
      if (mism) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (!error) begin
          error    <= 1'b1;
          err_addr <= s1_addr;
          err_exp  <= s1_exp;
          err_got  <= s1_data;
        end
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            err_count  <= '0;
            err_addr   <= '0;
            err_exp    <= '0;
            err_got    <= '0;
            pass_count <= '0;
          end
        end
        S_WR: begin
          if (bus.wr_req && bus.wr_ack) begin
            bus.wr_data <= wr_next;
            wr_lf       <= lfsr_step(wr_lf);
            wa          <= wa + AW'(1);
            if (wcnt == BLAST) begin
              wcnt       <= '0;
              bus.wr_req <= 1'b0;
              state      <= S_WGAP;
            end else begin
              wcnt <= wcnt + CW'(1);
            end
          end
        end
        S_WGAP: begin
          if (bus.wr_addr == LAST_BURST) begin
            bus.rd_addr <= '0;
            bus.rd_req  <= 1'b1;
            rd_lf       <= lfsr_seed(seed_q);
            chk_addr    <= '0;
            state       <= S_RD;
          end else begin
            bus.wr_addr <= bus.wr_addr + BSTEP;
            bus.wr_req  <= 1'b1;
            state       <= S_WR;
          end
        end
        S_RD: begin
          if (bus.rd_req && bus.rd_ack) begin
            bus.rd_req <= 1'b0;
            rd_out     <= 1'b1;
          end
          if (take) begin
            if (rcnt == BLAST) begin
              rcnt   <= '0;
              rd_out <= 1'b0;
              state  <= (bus.rd_addr == LAST_BURST) ? S_FIN : S_RGAP;
            end else begin
              rcnt <= rcnt + CW'(1);
            end
          end
        end
        S_RGAP: begin
          bus.rd_addr <= bus.rd_addr + BSTEP;
          bus.rd_req  <= 1'b1;
          state       <= S_RD;
        end
        S_FIN: begin
          pass_count <= pass_count + 16'd1;
          if (!loop) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // New pass: relatch pattern controls and present the first write word.
      if (restart) begin
        mode_q      <= mode;
        seed_q      <= seed;
        wr_lf       <= lfsr_seed(seed);
        wa          <= '0;
        wcnt        <= '0;
        bus.wr_addr <= '0;
        bus.wr_data <= first_word;
        bus.wr_req  <= 1'b1;
        state       <= S_WR;
      end
    end
  end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester: memory responder model plus directed runs
// checked against a pattern reference computed from address arithmetic.
module tb_sdram_pattern_tester;

  localparam int unsigned BURST = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        loop = 1'b0;
  logic [15:0] seed = 16'd0;
  logic        busy, done, error;
  logic [15:0] err_count, pass_count;
  logic [24:0] err_addr;
  logic [15:0] err_exp, err_got;

  sdram_pattern_tester_if #(.AW(25), .DWIDTH(16)) bus ();

  sdram_pattern_tester #(
    .BANKBITS(2), .ROWBITS(13), .COLBITS(10), .DWIDTH(16), .BURST(BURST), .LAST_ADDR(64'd63)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .loop(loop), .seed(seed),
    .busy(busy), .done(done), .error(error), .err_count(err_count), .err_addr(err_addr),
    .err_exp(err_exp), .err_got(err_got), .pass_count(pass_count), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (got === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference pattern straight from the address rules.
  function automatic logic [15:0] ref_pat(input int m, input logic [15:0] sd, input int unsigned a);
    logic [15:0] s;
    case (m)
      0: return 16'(a ^ (a >> 16));
      1: return ~16'(a ^ (a >> 16));
      2: begin
        s = (sd == 16'd0) ? 16'd1 : sd;
        for (int i = 0; i < int'(a); i++) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
        return s;
      end
      default: return 16'd1 << (a % 16);
    endcase
  endfunction

  // Responder model state and run statistics.
  logic [15:0]  mem [64];
  int           cyc = 0;
  int           last_wack = -100;
  int           last_rdy = -100;
  int           wk = 0;
  int           rrem = 0;
  int           ridx = 0;
  int unsigned  rbase = 0;
  bit           prev_wr = 1'b0;
  bit           prev_rd = 1'b0;
  int           flip_addr = -1;
  bit           stuck = 1'b0;
  bit           wstall = 1'b0;
  bit           rgap = 1'b0;
  bit           stray_on = 1'b0;
  int           wr_bad = 0;
  int           tim_bad = 0;
  logic [15:0]  wd5 = 16'd0;
  int           cur_mode = 0;
  logic [15:0]  cur_seed = 16'd0;
  int unsigned  wbursts[$];
  int unsigned  rbursts[$];

  initial begin
    int unsigned a;
    logic [15:0] d;
    bus.wr_ack = 1'b0; bus.rd_ack = 1'b0; bus.rd_rdy = 1'b0; bus.rd_data = 16'd0;
    forever begin
      @(posedge clk); #1;
      cyc = cyc + 1;
      bus.wr_ack = 1'b0; bus.rd_ack = 1'b0; bus.rd_rdy = 1'b0;
      if (!reset_n) begin
        wk = 0; rrem = 0; prev_wr = 1'b0; prev_rd = 1'b0;
        continue;
      end
      // Write side: bursts must be spaced by one idle cycle after the last ack.
      if (bus.wr_req && !prev_wr) begin
        if (bus.wr_addr != 25'd0 && (cyc - last_wack) != 2) tim_bad = tim_bad + 1;
        wbursts.push_back(32'(bus.wr_addr));
      end
      prev_wr = bus.wr_req;
      if (bus.wr_req && (!wstall || (cyc % 3) == 0)) begin
        a = 32'(bus.wr_addr) + wk;
        if (bus.wr_data !== ref_pat(cur_mode, cur_seed, a)) wr_bad = wr_bad + 1;
        if (a == 5) wd5 = bus.wr_data;
        mem[a % 64] = bus.wr_data;
        bus.wr_ack = 1'b1;
        last_wack = cyc;
        wk = (wk == BURST - 1) ? 0 : wk + 1;
      end
      // Read side.
      if (bus.rd_req && !prev_rd) begin
        if (bus.rd_addr == 25'd0) begin
          if ((cyc - last_wack) != 2) tim_bad = tim_bad + 1;
        end else if ((cyc - last_rdy) != 2) tim_bad = tim_bad + 1;
        rbursts.push_back(32'(bus.rd_addr));
      end
      prev_rd = bus.rd_req;
      if (stray_on) begin
        bus.rd_rdy = 1'b1; bus.rd_data = 16'd0;
      end else if (rrem > 0) begin
        if (!rgap || $urandom_range(0, 2) != 0) begin
          a = rbase + ridx;
          d = stuck ? 16'd0 : mem[a % 64];
          if (int'(a) == flip_addr) d = d ^ 16'h0008;
          bus.rd_rdy = 1'b1; bus.rd_data = d;
          ridx = ridx + 1; rrem = rrem - 1; last_rdy = cyc;
        end
      end else if (bus.rd_req) begin
        if (!rgap || $urandom_range(0, 1) == 0) begin
          bus.rd_ack = 1'b1; rrem = BURST; rbase = 32'(bus.rd_addr); ridx = 0;
        end
      end
    end
  end

  task automatic clear_stats();
    wr_bad = 0; tim_bad = 0; wbursts.delete(); rbursts.delete();
  endtask

  task automatic do_start(input int m, input logic [15:0] sd, input logic lp);
    mode = 2'(m); seed = sd; loop = lp; cur_mode = m; cur_seed = sd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n = n + 1;
    end
    chk("done_within_budget", 64'(done), 64'd1);
  endtask

  initial begin
    int bad;
    int n;
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_error", 64'(error), 0);
    chk("rst_wr_req", 64'(bus.wr_req), 0);
    chk("rst_rd_req", 64'(bus.rd_req), 0);
    chk("rst_err_count", 64'(err_count), 0);
    chk("rst_pass_count", 64'(pass_count), 0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 0);
    chk("rst_wr_data", 64'(bus.wr_data), 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Single pass, fold pattern, zero-latency memory.
    clear_stats();
    do_start(0, 16'd0, 1'b0);
    chk("start_wr_req", 64'(bus.wr_req), 1);
    chk("start_busy", 64'(busy), 1);
    chk("start_wr_addr", 64'(bus.wr_addr), 0);
    chk("start_wr_data", 64'(bus.wr_data), 64'(ref_pat(0, 16'd0, 0)));
    chk("wr_len", 64'(bus.wr_len), 3);
    chk("rd_len", 64'(bus.rd_len), 3);
    wait_done(5000);
    chk("a_busy", 64'(busy), 0);
    chk("a_error", 64'(error), 0);
    chk("a_err_count", 64'(err_count), 0);
    chk("a_pass_count", 64'(pass_count), 1);
    chk("a_wd5", 64'(wd5), 64'h0005);
    chk("a_wr_bursts", 64'(wbursts.size()), 16);
    chk("a_rd_bursts", 64'(rbursts.size()), 16);
    bad = 0;
    foreach (wbursts[i]) if (wbursts[i] != 32'(i * 4)) bad = bad + 1;
    foreach (rbursts[i]) if (rbursts[i] != 32'(i * 4)) bad = bad + 1;
    chk("a_burst_addr_seq", 64'(bad), 0);
    chk("a_wr_words", 64'(wr_bad), 0);
    chk("a_timing", 64'(tim_bad), 0);

    // Single bit flip on readback, inverted fold pattern.
    clear_stats();
    flip_addr = 32'h21;
    do_start(1, 16'd0, 1'b0);
    wait_done(5000);
    flip_addr = -1;
    chk("b_error", 64'(error), 1);
    chk("b_err_count", 64'(err_count), 1);
    chk("b_err_addr", 64'(err_addr), 64'h21);
    chk("b_err_exp", 64'(err_exp), 64'hFFDE);
    chk("b_err_got", 64'(err_got), 64'hFFD6);
    chk("b_pass_count", 64'(pass_count), 1);
    chk("b_wr_words", 64'(wr_bad), 0);

    // LFSR pattern with a stalling memory.
    clear_stats();
    wstall = 1'b1; rgap = 1'b1;
    do_start(2, 16'hACE1, 1'b0);
    chk("c_first_word", 64'(bus.wr_data), 64'hACE1);
    wait_done(20000);
    wstall = 1'b0; rgap = 1'b0;
    chk("c_error", 64'(error), 0);
    chk("c_err_count", 64'(err_count), 0);
    chk("c_wr_words", 64'(wr_bad), 0);
    chk("c_timing", 64'(tim_bad), 0);
    chk("c_rd_bursts", 64'(rbursts.size()), 16);

    // Looping walking-one passes, then stop after the current pass.
    clear_stats();
    do_start(3, 16'd0, 1'b1);
    n = 0;
    while (pass_count != 16'd3 && n < 20000) begin
      @(posedge clk); #1;
      n = n + 1;
    end
    chk("d_pass3", 64'(pass_count), 3);
    chk("d_busy_looping", 64'(busy), 1);
    chk("d_done_looping", 64'(done), 0);
    loop = 1'b0;
    wait_done(5000);
    chk("d_pass_count", 64'(pass_count), 4);
    chk("d_busy_end", 64'(busy), 0);
    chk("d_error", 64'(error), 0);
    chk("d_wr_words", 64'(wr_bad), 0);
    chk("d_timing", 64'(tim_bad), 0);

    // Stuck-at-zero memory: every word mismatches.
    clear_stats();
    stuck = 1'b1;
    do_start(1, 16'd0, 1'b0);
    chk("e_start_clears_pass", 64'(pass_count), 0);
    wait_done(5000);
    stuck = 1'b0;
    chk("e_err_count", 64'(err_count), 64);
    chk("e_err_addr", 64'(err_addr), 0);
    chk("e_err_exp", 64'(err_exp), 64'hFFFF);
    chk("e_err_got", 64'(err_got), 0);
    // A single unsolicited rd_rdy is a mismatch.
    @(negedge clk) stray_on = 1'b1;
    @(negedge clk) stray_on = 1'b0;
    repeat (3) @(negedge clk);
    chk("e_stray_count", 64'(err_count), 65);
    chk("e_stray_keeps_first", 64'(err_addr), 0);
    // Flood past the counter limit.
    @(negedge clk) stray_on = 1'b1;
    repeat (65480) @(negedge clk);
    stray_on = 1'b0;
    repeat (3) @(negedge clk);
    chk("e_saturate", 64'(err_count), 64'hFFFF);
    chk("e_error_sticky", 64'(error), 1);

    // Asynchronous reset in the middle of the third write burst.
    @(posedge clk); #1;
    clear_stats();
    do_start(0, 16'd0, 1'b0);
    chk("f_start_clears_err", 64'(err_count), 0);
    n = 0;
    while (!(bus.wr_req && bus.wr_addr == 25'd8) && n < 200) begin
      @(posedge clk); #1;
      n = n + 1;
    end
    @(posedge clk); #2;
    chk("f_mid_burst_req", 64'(bus.wr_req), 1);
    reset_n = 1'b0;
    #1;
    chk("f_rst_wr_req", 64'(bus.wr_req), 0);
    chk("f_rst_busy", 64'(busy), 0);
    chk("f_rst_done", 64'(done), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    clear_stats();
    do_start(0, 16'd0, 1'b0);
    chk("f_restart_wr_addr", 64'(bus.wr_addr), 0);
    chk("f_restart_wr_req", 64'(bus.wr_req), 1);
    wait_done(5000);
    chk("f_error", 64'(error), 0);
    chk("f_pass_count", 64'(pass_count), 1);
    chk("f_wr_words", 64'(wr_bad), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
